// File: rtl/bp_ghr_ctrl.sv
// bp_ghr_ctrl: branch-history / index controller for a 2-bit PHT.
// Front end forms the lookup index and speculatively updates history.
// Back end keeps in-flight branches in order and drives table updates.
// The queue never accepts a branch while full, even if one pops that cycle.
// Build option: define BP_GSHARE_EN for gshare indexing (PC XOR history);
// without it the block is bimodal (PC-only index, no history storage).
module bp_ghr_ctrl #(
   parameter int GHR_W = 10,
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] if_pc,
   input  logic        op_bxx,
   input  logic        pht_prehit,
   input  logic        ex_resolve,
   input  logic        ex_taken,
   input  logic        flush,
   output logic [9:0]  pht_index,
   output logic [9:0]  fix_index,
   output logic        presuccess,
   output logic        prefail,
   output logic        mispredict,
   output logic        bq_full
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   // In-flight branch queue storage (index and prediction per entry)
   logic [9:0]       q_idx [DEPTH];
   logic [DEPTH-1:0] q_pred;

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;

   logic [9:0] head_idx;
   logic       head_pred;
   logic       pop;
   logic       push;
   logic       mispredict_now;

   // Only PC bits [11:2] feed the index
   logic unused_pc;
   assign unused_pc = ^{if_pc[31:12], if_pc[1:0]};

   assign head_idx  = q_idx[rd_ptr];
   assign head_pred = q_pred[rd_ptr];
   assign bq_full   = (count == CNT_W'(DEPTH));

   // Flush beats everything; a mispredict kills any same-cycle push
   assign pop            = ex_resolve & (count != '0) & ~flush;
   assign mispredict_now = pop & (ex_taken != head_pred);
   assign push           = op_bxx & ~bq_full & ~flush & ~mispredict_now;

`ifdef BP_GSHARE_EN
   typedef logic [GHR_W-1:0] ghr_t;

   ghr_t spec_ghr;
   ghr_t arch_ghr;
   ghr_t q_snap [DEPTH];
   ghr_t head_snap;

   assign head_snap = q_snap[rd_ptr];
   assign pht_index = if_pc[11:2] ^ 10'(spec_ghr);

   // History registers: committed on pop, speculative on push, restored on flush/mispredict
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         spec_ghr <= '0;
         arch_ghr <= '0;
      end else begin
         if (pop)
            arch_ghr <= ghr_t'({arch_ghr, ex_taken});
         if (flush)
            spec_ghr <= arch_ghr;
         else if (mispredict_now)
            spec_ghr <= ghr_t'({head_snap, ex_taken});
         else if (push)
            spec_ghr <= ghr_t'({spec_ghr, pht_prehit});
      end
   end

   // History snapshot storage written alongside each pushed entry
   always_ff @(posedge clk) begin
      if (push)
         q_snap[wr_ptr] <= spec_ghr;
   end
`else
   assign pht_index = if_pc[11:2];
`endif

   // Entry payload storage; contents are don't-care while not counted
   always_ff @(posedge clk) begin
      if (push) begin
         q_idx[wr_ptr]  <= pht_index;
         q_pred[wr_ptr] <= pht_prehit;
      end
   end

   // Queue pointers and occupancy; pointers wrap naturally (power-of-two depth)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush | mispredict_now) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push & ~pop)
            count <= count + 1'b1;
         else if (pop & ~push)
            count <= count - 1'b1;
      end
   end

   // Registered PHT update strobes and mispredict pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fix_index  <= '0;
         presuccess <= 1'b0;
         prefail    <= 1'b0;
         mispredict <= 1'b0;
      end else begin
         presuccess <= pop & ex_taken;
         prefail    <= pop & ~ex_taken;
         mispredict <= mispredict_now;
         if (pop)
            fix_index <= head_idx;
      end
   end

endmodule

// File: tb/tb_bp_ghr_ctrl.sv
// tb_bp_ghr_ctrl: scoreboard bench for bp_ghr_ctrl.
// Expected strobes are queued when a cycle's stimulus is driven and
// compared one clock later; a small behavioural queue/history model
// supplies the expected values. Works in both BP_GSHARE_EN builds.
module tb_bp_ghr_ctrl;

   localparam int DEPTH = 4;
`ifdef BP_GSHARE_EN
   localparam bit GSHARE = 1'b1;
`else
   localparam bit GSHARE = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] if_pc = '0;
   logic        op_bxx = 1'b0;
   logic        pht_prehit = 1'b0;
   logic        ex_resolve = 1'b0;
   logic        ex_taken = 1'b0;
   logic        flush = 1'b0;
   logic [9:0]  pht_index;
   logic [9:0]  fix_index;
   logic        presuccess;
   logic        prefail;
   logic        mispredict;
   logic        bq_full;

   bp_ghr_ctrl #(.GHR_W(10), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .if_pc      (if_pc),
      .op_bxx     (op_bxx),
      .pht_prehit (pht_prehit),
      .ex_resolve (ex_resolve),
      .ex_taken   (ex_taken),
      .flush      (flush),
      .pht_index  (pht_index),
      .fix_index  (fix_index),
      .presuccess (presuccess),
      .prefail    (prefail),
      .mispredict (mispredict),
      .bq_full    (bq_full)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       ps;
      logic       pf;
      logic       mp;
      logic [9:0] fi;
   } exp_t;

   exp_t exp_q[$];

   // Behavioural model state
   logic [9:0] m_idx[$];
   logic       m_pred[$];
   logic [9:0] m_snap[$];
   logic [9:0] m_spec;
   logic [9:0] m_arch;
   logic [9:0] m_fix;

   int n_vec = 0;
   int n_err = 0;
   int n_txn = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic idle();
      op_bxx = 1'b0;
      pht_prehit = 1'b0;
      ex_resolve = 1'b0;
      ex_taken = 1'b0;
      flush = 1'b0;
   endtask

   task automatic model_clear();
      m_idx.delete();
      m_pred.delete();
      m_snap.delete();
      exp_q.delete();
      m_spec = '0;
      m_arch = '0;
      m_fix = '0;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      model_clear();
      rst_n = 1'b1;
   endtask

   // One clock of stimulus: check combinational outputs, queue expected
   // registered outputs, advance the model, then compare after the edge.
   task automatic step(input logic op, input logic pre, input logic [31:0] pc,
                       input logic res, input logic tk, input logic fl);
      exp_t e;
      logic full, pop, mis, push;
      logic [9:0] idx;
      if_pc = pc;
      op_bxx = op;
      pht_prehit = pre;
      ex_resolve = res;
      ex_taken = tk;
      flush = fl;
      #1;
      n_txn++;
      $display("txn %0d: op=%0b pre=%0b pc=%08h res=%0b tk=%0b fl=%0b inflight=%0d",
               n_txn, op, pre, pc, res, tk, fl, m_idx.size());
      idx  = pc[11:2] ^ (GSHARE ? m_spec : 10'h000);
      full = (m_idx.size() == DEPTH);
      pop  = res && (m_idx.size() != 0) && !fl;
      mis  = pop && (tk != m_pred[0]);
      push = op && !full && !fl && !mis;
      chk("pht_index", pht_index, idx);
      chk("bq_full", bq_full, full);
      e.ps = pop && tk;
      e.pf = pop && !tk;
      e.mp = mis;
      e.fi = pop ? m_idx[0] : m_fix;
      exp_q.push_back(e);
      @(posedge clk);
      m_fix = e.fi;
      if (fl) begin
         m_idx.delete(); m_pred.delete(); m_snap.delete();
         m_spec = m_arch;
      end else if (mis) begin
         m_arch = {m_arch[8:0], tk};
         m_spec = {m_snap[0][8:0], tk};
         m_idx.delete(); m_pred.delete(); m_snap.delete();
      end else begin
         if (pop) begin
            m_arch = {m_arch[8:0], tk};
            void'(m_idx.pop_front());
            void'(m_pred.pop_front());
            void'(m_snap.pop_front());
         end
         if (push) begin
            m_idx.push_back(idx);
            m_pred.push_back(pre);
            m_snap.push_back(m_spec);
            m_spec = {m_spec[8:0], pre};
         end
      end
      @(negedge clk);
      e = exp_q.pop_front();
      chk("presuccess", presuccess, e.ps);
      chk("prefail", prefail, e.pf);
      chk("mispredict", mispredict, e.mp);
      chk("fix_index", fix_index, e.fi);
      chk("strobe_excl", presuccess & prefail, 1'b0);
   endtask

   initial begin
      logic tk;
      model_clear();
      do_reset();

      // Reset state
      if_pc = 32'h0000_0040;
      #1;
      chk("rst_index", pht_index, 10'h010);
      chk("rst_full", bq_full, 1'b0);
      chk("rst_strobes", {presuccess, prefail, mispredict}, 3'b000);
      chk("rst_fix", fix_index, 10'h000);
      step(0, 0, 32'h0000_0040, 0, 0, 0);

      // Three taken predictions build history 0x007
      step(1, 1, 32'h0000_0100, 0, 0, 0);
      step(1, 1, 32'h0000_0204, 0, 0, 0);
      step(1, 1, 32'h0000_0308, 0, 0, 0);
      idle();
      if_pc = 32'h0000_0040;
      #1;
      chk("hash_taken", pht_index, GSHARE ? 10'h017 : 10'h010);
      for (int i = 0; i < 3; i++) step(0, 0, 32'h0000_0040, 1, 1, 0);
      step(0, 0, 32'h0000_0040, 1, 1, 0);

      // Queue full and stall
      do_reset();
      step(1, 1, 32'h0000_1000, 0, 0, 0);
      step(1, 0, 32'h0000_2004, 0, 0, 0);
      step(1, 1, 32'h0000_3008, 0, 0, 0);
      step(1, 0, 32'h0000_400C, 0, 0, 0);
      idle();
      #1;
      chk("full_const", bq_full, 1'b1);
      step(1, 1, 32'h0000_0040, 0, 0, 0);
      step(1, 1, 32'h0000_0050, 1, m_pred[0], 0);
      step(1, 0, 32'h0000_0060, 1, m_pred[0], 0);
      idle();
      #1;
      chk("pushpop_notfull", bq_full, 1'b0);
      step(1, 1, 32'h0000_0070, 0, 0, 0);
      idle();
      #1;
      chk("refill_full", bq_full, 1'b1);

      // Mispredict recovery
      do_reset();
      step(1, 1, 32'h0000_0080, 0, 0, 0);
      step(1, 0, 32'h0000_00C0, 0, 0, 0);
      step(0, 0, 32'h0000_0040, 1, 0, 0);
      chk("mp_fix", fix_index, 10'h020);
      chk("mp_pulse", {prefail, mispredict}, 2'b11);
      idle();
      if_pc = 32'h0000_0040;
      #1;
      chk("mp_ghr", pht_index, 10'h010);
      step(0, 0, 32'h0000_0040, 1, 1, 0);

      // Flush with a simultaneous resolve
      do_reset();
      step(1, 1, 32'h0000_0100, 0, 0, 0);
      step(0, 0, 32'h0000_0000, 1, 1, 0);
      step(1, 1, 32'h0000_0104, 0, 0, 0);
      step(1, 0, 32'h0000_0108, 0, 0, 0);
      step(0, 0, 32'h0000_0040, 1, 1, 1);
      idle();
      if_pc = 32'h0000_0040;
      #1;
      chk("flush_ghr", pht_index, GSHARE ? 10'h011 : 10'h010);
      step(0, 0, 32'h0000_0040, 1, 1, 0);

      // Random traffic exercising wrap, mixed push/pop and flush
      do_reset();
      for (int i = 0; i < 120; i++) begin
         tk = (m_pred.size() != 0 && $urandom_range(0, 3) != 0) ? m_pred[0] : 1'($urandom_range(0, 1));
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
              1'($urandom_range(0, 2) != 0), tk, 1'($urandom_range(0, 24) == 0));
      end

      // Asynchronous reset mid-cycle with entries in flight
      do_reset();
      step(1, 1, 32'h0000_0104, 0, 0, 0);
      step(1, 1, 32'h0000_0208, 0, 0, 0);
      step(1, 0, 32'h0000_030C, 0, 0, 0);
      step(1, 1, 32'h0000_0410, 0, 0, 0);
      step(0, 0, 32'h0000_0040, 1, 1, 0);
      idle();
      if_pc = 32'h0000_0040;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_presuccess", presuccess, 1'b0);
      chk("arst_prefail", prefail, 1'b0);
      chk("arst_mispredict", mispredict, 1'b0);
      chk("arst_fix", fix_index, 10'h000);
      chk("arst_full", bq_full, 1'b0);
      chk("arst_index", pht_index, 10'h010);
      @(negedge clk);
      model_clear();
      rst_n = 1'b1;
      step(0, 0, 32'h0000_0040, 1, 1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
